// File: rtl/bic_tx_scheduler.sv
// Purpose: shares one bicTransmit serializer between source A (keyboard) and
//   source B (protocol/echo) with round-robin grants, inter-frame gap and a
//   no-completion timeout; counts completed frames.
// Latency: req -> ack/transEn 1 cycle; charSent -> transEn low 1 cycle.
// Backpressure: a requester holds req until its ack; requests wait while busy.
// Ports:
//   srClock, rst          clock (rising edge), async active-low reset
//   req_x, data_x, ack_x  per-source request, character, one-cycle grant
//   tx_char, transEn      character and enable driven to bicTransmit
//   charSent              frame-complete from bicTransmit (SEND only)
//   busy, timeout_err     not-idle status, one-cycle abandoned-frame pulse
//   sent_count            completed frames, wraps 255 -> 0
module bic_tx_scheduler #(
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              srClock,
  input  logic              rst,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] tx_char,
  output logic              transEn,
  input  logic              charSent,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        sent_count
);

  // One counter serves as the SEND timer and the GAP counter.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_b_q, prio_b_d;   // 1: B wins the next tie
  logic [DATA_W-1:0] tx_char_q, tx_char_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              tout_q, tout_d;
  logic [7:0]        sent_q, sent_d;
  logic              trans_en_q, trans_en_d;
  logic              busy_q, busy_d;
  logic              grant_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_b_d  = prio_b_q;
    tx_char_d = tx_char_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    tout_d    = 1'b0;
    sent_d    = sent_q;
    grant_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          grant_b   = req_b && (!req_a || prio_b_q);
          tx_char_d = grant_b ? data_b : data_a;
          ack_a_d   = !grant_b;
          ack_b_d   = grant_b;
          prio_b_d  = !grant_b;
          cnt_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (charSent) begin
          sent_d  = sent_q + 8'd1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    trans_en_d = (state_d == SEND);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prio_b_q   <= 1'b0;
      tx_char_q  <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      tout_q     <= 1'b0;
      sent_q     <= 8'd0;
      trans_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_b_q   <= prio_b_d;
      tx_char_q  <= tx_char_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      tout_q     <= tout_d;
      sent_q     <= sent_d;
      trans_en_q <= trans_en_d;
      busy_q     <= busy_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign tx_char     = tx_char_q;
  assign transEn     = trans_en_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;
  assign sent_count  = sent_q;

endmodule

// File: tb/tb_bic_tx_scheduler.sv
module tb_bic_tx_scheduler;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TO  = 64;
  localparam int NV  = 28;

  logic          srClock = 1'b0;
  logic          rst;
  logic          req_a, req_b, charSent;
  logic [DW-1:0] data_a, data_b;
  logic          ack_a, ack_b, transEn, busy, timeout_err;
  logic [DW-1:0] tx_char;
  logic [7:0]    sent_count;

  bic_tx_scheduler #(.DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .srClock(srClock), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .tx_char(tx_char), .transEn(transEn), .charSent(charSent),
    .busy(busy), .timeout_err(timeout_err), .sent_count(sent_count)
  );

  always #5 srClock = ~srClock;

  typedef struct packed {
    logic       ack_a;
    logic       ack_b;
    logic [7:0] tx;
    logic       en;
    logic       busy;
    logic       to;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    logic       ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic       cs;
    out_t       exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tab [NV];

  // Reference model: frame timing expressed as edge numbers.
  logic       m_send;
  int         m_start, m_gap_end;
  logic       m_fav_b;
  logic [7:0] m_tx, m_cnt;
  out_t       m_exp;

  task automatic step();
    @(posedge srClock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input out_t e);
    chk({tag, ".ack_a"},       32'(ack_a),       32'(e.ack_a));
    chk({tag, ".ack_b"},       32'(ack_b),       32'(e.ack_b));
    chk({tag, ".tx_char"},     32'(tx_char),     32'(e.tx));
    chk({tag, ".transEn"},     32'(transEn),     32'(e.en));
    chk({tag, ".busy"},        32'(busy),        32'(e.busy));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(e.to));
    chk({tag, ".sent_count"},  32'(sent_count),  32'(e.cnt));
  endtask

  function automatic out_t mo(int aa, int ab, int tx, int en, int bs, int to, int cnt);
    out_t o;
    o.ack_a = 1'(aa); o.ack_b = 1'(ab); o.tx = 8'(tx); o.en = 1'(en);
    o.busy = 1'(bs); o.to = 1'(to); o.cnt = 8'(cnt);
    return o;
  endfunction

  function automatic vec_t mk(int ra, int da, int rb, int db, int cs,
                              int aa, int ab, int tx, int en, int bs, int to, int cnt);
    vec_t v;
    v.ra = 1'(ra); v.da = 8'(da); v.rb = 1'(rb); v.db = 8'(db); v.cs = 1'(cs);
    v.exp = mo(aa, ab, tx, en, bs, to, cnt);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; charSent = 1'b0;
    data_a = '0; data_b = '0;
    repeat (2) @(posedge srClock);
    #1;
    rst = 1'b1;
  endtask

  task automatic model_edge(input int n, input logic ra, input logic [7:0] da,
                            input logic rb, input logic [7:0] db, input logic cs);
    logic pick_b;
    m_exp.ack_a = 1'b0;
    m_exp.ack_b = 1'b0;
    m_exp.to    = 1'b0;
    if (m_send) begin
      if (cs) begin
        m_cnt = m_cnt + 8'd1;
        m_send = 1'b0;
        m_gap_end = n + GAP;
      end else if (n - m_start == TO) begin
        m_exp.to = 1'b1;
        m_send = 1'b0;
        m_gap_end = n + GAP;
      end
    end else if (n > m_gap_end && (ra || rb)) begin
      pick_b = rb && (!ra || m_fav_b);
      m_fav_b = !pick_b;
      m_tx = pick_b ? db : da;
      m_send = 1'b1;
      m_start = n;
      m_exp.ack_a = !pick_b;
      m_exp.ack_b = pick_b;
    end
    m_exp.tx   = m_tx;
    m_exp.en   = m_send;
    m_exp.busy = m_send || (n < m_gap_end);
    m_exp.cnt  = m_cnt;
  endtask

  initial begin
    int hi;
    int got;
    int cs_pct;

    // Per-cycle vectors: single send, gap boundaries, ignored charSent, contention.
    tab[0]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 0, 0);
    tab[1]  = mk(1, 8'h41, 0, 8'h00, 0,  1, 0, 8'h41, 1, 1, 0, 0);
    tab[2]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h41, 1, 1, 0, 0);
    tab[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h41, 0, 1, 0, 1);
    tab[4]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h41, 0, 1, 0, 1);
    tab[5]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h41, 0, 1, 0, 1);
    tab[6]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h41, 0, 1, 0, 1);
    tab[7]  = mk(0, 8'h00, 1, 8'h42, 0,  0, 0, 8'h41, 0, 0, 0, 1);
    tab[8]  = mk(0, 8'h00, 1, 8'h42, 0,  0, 1, 8'h42, 1, 1, 0, 1);
    tab[9]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h42, 0, 1, 0, 2);
    tab[10] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h42, 0, 1, 0, 2);
    tab[11] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h42, 0, 1, 0, 2);
    tab[12] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h42, 0, 1, 0, 2);
    tab[13] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h42, 0, 0, 0, 2);
    tab[14] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h42, 0, 0, 0, 2);
    tab[15] = mk(1, 8'h41, 1, 8'h42, 0,  1, 0, 8'h41, 1, 1, 0, 2);
    tab[16] = mk(1, 8'h41, 1, 8'h42, 1,  0, 0, 8'h41, 0, 1, 0, 3);
    tab[17] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h41, 0, 1, 0, 3);
    tab[18] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h41, 0, 1, 0, 3);
    tab[19] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h41, 0, 1, 0, 3);
    tab[20] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h41, 0, 0, 0, 3);
    tab[21] = mk(1, 8'h41, 1, 8'h42, 0,  0, 1, 8'h42, 1, 1, 0, 3);
    tab[22] = mk(1, 8'h41, 1, 8'h42, 1,  0, 0, 8'h42, 0, 1, 0, 4);
    tab[23] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h42, 0, 1, 0, 4);
    tab[24] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h42, 0, 1, 0, 4);
    tab[25] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h42, 0, 1, 0, 4);
    tab[26] = mk(1, 8'h41, 1, 8'h42, 0,  0, 0, 8'h42, 0, 0, 0, 4);
    tab[27] = mk(1, 8'h41, 1, 8'h42, 0,  1, 0, 8'h41, 1, 1, 0, 4);

    do_reset();
    chk_outs("reset", mo(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < NV; i++) begin
      req_a = tab[i].ra; data_a = tab[i].da;
      req_b = tab[i].rb; data_b = tab[i].db;
      charSent = tab[i].cs;
      step();
      chk_outs($sformatf("vec%0d", i), tab[i].exp);
    end

    // Asynchronous reset in the middle of a frame.
    req_a = 1'b0; req_b = 1'b0; charSent = 1'b0;
    #2 rst = 1'b0;
    #1 chk_outs("midreset", mo(0, 0, 0, 0, 0, 0, 0));
    @(posedge srClock);
    #1 rst = 1'b1;
    step();
    chk_outs("post_reset", mo(0, 0, 0, 0, 0, 0, 0));

    // Timeout: A granted, B waits, charSent never comes.
    req_a = 1'b1; data_a = 8'h55;
    step();
    chk_outs("to_grant", mo(1, 0, 8'h55, 1, 1, 0, 0));
    req_a = 1'b0; req_b = 1'b1; data_b = 8'h66;
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (transEn !== 1'b1) break;
      hi++;
    end
    chk("timeout_len", 32'(hi), 32'(TO));
    chk("timeout_pulse", 32'(timeout_err), 32'd1);
    chk("timeout_cnt", 32'(sent_count), 32'd0);
    req_a = 1'b1; data_a = 8'h77;
    step();
    chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_a || ack_b) begin got = 1; break; end
    end
    chk("after_to_ack_seen", 32'(got), 32'd1);
    chk("after_to_ack_b", 32'(ack_b), 32'd1);
    chk("after_to_ack_a", 32'(ack_a), 32'd0);
    chk("after_to_tx", 32'(tx_char), 32'h66);

    // charSent in the last cycle before timeout expiry counts as success.
    req_a = 1'b0; req_b = 1'b0;
    repeat (TO - 1) step();
    chk("last_cycle_en", 32'(transEn), 32'd1);
    charSent = 1'b1;
    step();
    charSent = 1'b0;
    chk_outs("last_cycle_done", mo(0, 0, 8'h66, 0, 1, 0, 1));
    step();
    chk("last_cycle_no_to", 32'(timeout_err), 32'd0);

    // 256 completed frames wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      req_a = 1'b1; data_a = 8'(i);
      step();
      req_a = 1'b0; charSent = 1'b1;
      step();
      charSent = 1'b0;
      if (i == 254) chk("wrap_255", 32'(sent_count), 32'd255);
      repeat (GAP) step();
    end
    chk("wrap_0", 32'(sent_count), 32'd0);
    chk("wrap_idle", 32'(busy), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    m_send = 1'b0; m_start = 0; m_gap_end = -1; m_fav_b = 1'b0;
    m_tx = 8'h00; m_cnt = 8'h00;
    cs_pct = 10;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       cs_pct = 2;
          1:       cs_pct = 10;
          default: cs_pct = 40;
        endcase
      end
      if (!req_a && $urandom_range(0, 2) == 0) begin req_a = 1'b1; data_a = 8'($urandom); end
      if (!req_b && $urandom_range(0, 2) == 0) begin req_b = 1'b1; data_b = 8'($urandom); end
      charSent = ($urandom_range(0, 99) < cs_pct);
      model_edge(n, req_a, data_a, req_b, data_b, charSent);
      step();
      chk_outs($sformatf("rand%0d", n), m_exp);
      chk("rand_ack_excl", 32'(ack_a && ack_b), 32'd0);
      if (m_exp.ack_a) req_a = 1'b0;
      if (m_exp.ack_b) req_b = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bic_tx_scheduler.md
Name: bic_tx_scheduler

Overview:
- Shares the single bicTransmit serializer between two character sources: A, the local keyboard path, and B, the protocol/echo path.
- Arbitrates requests round-robin and latches the winning character onto tx_char.
- Drives transEn for the frame and waits for charSent.
- Enforces an inter-frame gap and a no-completion timeout, and keeps a count of frames sent.

Parameters:
DATA_W, 8, character width
GAP_CYCLES, 4, idle cycles between frames with transEn low (must be >=1)
TIMEOUT_CYCLES, 64, SEND cycles allowed before the frame is abandoned (must be >=2)

Ports:
srClock  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
req_a  input  1  source A requests a send; held until ack_a is seen
data_a  input  DATA_W  source A character; valid while req_a=1
ack_a  output  1  one-cycle pulse: A granted, data_a captured
req_b  input  1  source B request, same rules as A
data_b  input  DATA_W  source B character
ack_b  output  1  one-cycle pulse: B granted
tx_char  output  DATA_W  character presented to bicTransmit
transEn  output  1  transmit enable to bicTransmit
charSent  input  1  bicTransmit frame-complete indication
busy  output  1  high whenever state is not IDLE
timeout_err  output  1  one-cycle pulse: frame abandoned
sent_count  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; transEn=0, ack_a=0, ack_b=0, timeout_err=0, busy=0; tx_char=0, sent_count=0; round-robin pointer favours A.
  - Reset mid-frame drops transEn immediately. No partial state survives.
- All outputs are registered.
- States:
  - IDLE: transEn=0. If req_a or req_b is sampled high at edge N:
    - Winner: the only requester; if both, the one not granted last.
    - At edge N: tx_char<=winner's data, ack_<winner><=1 for exactly one cycle, pointer<=winner, timer<=0, state<=SEND.
    - From cycle N+1: transEn=1 and busy=1.
  - SEND: transEn=1; timer increments each cycle.
    - charSent=1 sampled: transEn<=0, sent_count<=sent_count+1, state<=GAP.
    - Else, timer reaches TIMEOUT_CYCLES-1: transEn<=0, timeout_err<=1 for one cycle, sent_count unchanged, state<=GAP.
    - charSent in the same cycle as timeout expiry: treated as success; no timeout_err.
  - GAP: transEn=0, busy=1. Counts GAP_CYCLES cycles, then state<=IDLE. Requests are not sampled in GAP.
- Latency:
  - req to ack: 1 cycle. req to transEn high: 1 cycle.
  - charSent to transEn low: 1 cycle.
  - Minimum back-to-back: the next grant is sampled in the first IDLE cycle after GAP.
- tx_char is stable from grant until the next grant. It changes only at a grant edge.
- charSent is ignored outside SEND; no count, no state change.
- Requesters must drop req within GAP_CYCLES cycles of seeing ack. A req still high when IDLE is re-entered is a new request.
- With both requesters continuously asserted, grants strictly alternate. The pointer updates only on a grant, never on a timeout.
- ack_a and ack_b are never high together.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release -> all outputs 0, busy=0, sent_count=0. Assert rst=0 mid-SEND -> transEn=0 in the same cycle; after release, state is IDLE and sent_count=0.
2. Single send: req_a=1 with data_a=0x41 at cycle 5 -> ack_a=1 in cycle 6 only, tx_char=0x41 and transEn=1 from cycle 6. Pulse charSent at cycle 16 -> transEn=0 at cycle 17, busy=1 for cycles 17-20, busy=0 at cycle 21, sent_count=1.
3. Contention: req_a=1 (0x41) and req_b=1 (0x42) together after reset, both held and re-asserted -> grant order A,B,A,B. tx_char sequence 0x41,0x42,0x41,0x42. Never both acks in one cycle.
4. Timeout: grant A and never assert charSent -> transEn high for exactly 64 cycles, then low. timeout_err pulses one cycle, sent_count unchanged. The next grant goes to B if B is requesting.
5. Edge cases:
   - charSent in the final timeout cycle -> success, sent_count+1, timeout_err=0.
   - charSent pulsed during IDLE and GAP -> ignored, sent_count unchanged.
   - 256 completed frames -> sent_count wraps to 0.
